// File: rtl/ram_sync_pkg.sv
// Shared types and helpers for the clearable synchronous RAM.
// The out-of-range helper is only called when RAM_SYNC_OOB_FAULT_EN is defined.
package ram_sync_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 11;

  // True when any address bit above the storage range is set.
  function automatic logic addr_oob(input logic [15:0] addr, input int unsigned aw);
    return (addr >> aw) != 16'd0;
  endfunction

endpackage

// File: rtl/ram_bank.sv
// Pure storage array: synchronous write, registered read, 1-cycle read latency.
// No control or reset, so the array maps cleanly onto BlockRAM; no backpressure.
module ram_bank #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    if (re) rdata <= mem[addr];
  end

endmodule

// File: rtl/ram_sync_clr.sv
// Single-port RAM with req/rvalid handshake and a clear sequencer (busy while clearing); read latency 1.
// No backpressure in READY; requests during busy are dropped. Optional macro: RAM_SYNC_OOB_FAULT_EN.
module ram_sync_clr
  import ram_sync_pkg::*;
#(
  parameter int                DATA_W  = DATA_W_DEF,
  parameter int                ADDR_W  = ADDR_W_DEF,
  parameter logic [DATA_W-1:0] CLR_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,
  input  logic              req,
  input  logic              load,
  input  logic [15:0]       address,
  input  logic [DATA_W-1:0] in,
  output logic [DATA_W-1:0] out,
  output logic              rvalid,
  output logic              busy,
  output logic              fault
);

  state_t            state, state_nx;
  logic [ADDR_W-1:0] clr_ptr, clr_ptr_nx;
  logic              bank_we, bank_re;
  logic [ADDR_W-1:0] bank_addr;
  logic [DATA_W-1:0] bank_wdata, bank_rdata;
  logic              rd_fire;
  logic              rd_zero;
  logic              oob;

`ifdef RAM_SYNC_OOB_FAULT_EN
  assign oob = addr_oob(address, ADDR_W);
`else
  logic unused_hi;
  assign oob       = 1'b0;
  assign unused_hi = ^address[15:ADDR_W];
`endif

  always_comb begin
    state_nx   = state;
    clr_ptr_nx = clr_ptr;
    bank_we    = 1'b0;
    bank_re    = 1'b0;
    bank_addr  = address[ADDR_W-1:0];
    bank_wdata = in;
    rd_fire    = 1'b0;
    case (state)
      CLEAR: begin
        bank_we    = 1'b1;
        bank_addr  = clr_ptr;
        bank_wdata = CLR_VAL;
        clr_ptr_nx = clr_ptr + ADDR_W'(1);
        if (clr_ptr == '1) state_nx = READY;
      end
      READY: begin
        // clear takes priority; a coincident request is dropped
        if (clear) begin
          state_nx   = CLEAR;
          clr_ptr_nx = '0;
        end else if (req) begin
          if (load) begin
            bank_we = !oob;
          end else begin
            rd_fire = 1'b1;
            bank_re = !oob;
          end
        end
      end
      default: state_nx = CLEAR;
    endcase
    if (reset) begin
      bank_we = 1'b0;
      bank_re = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= CLEAR;
      clr_ptr <= '0;
      rvalid  <= 1'b0;
      rd_zero <= 1'b1;
    end else begin
      state   <= state_nx;
      clr_ptr <= clr_ptr_nx;
      rvalid  <= rd_fire;
      if (rd_fire) rd_zero <= oob;
    end
  end

`ifdef RAM_SYNC_OOB_FAULT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      fault <= 1'b0;
    end else if (state == READY && !clear && req && oob) begin
      fault <= 1'b1;
    end
  end
`else
  assign fault = 1'b0;
`endif

  // rd_zero masks the uninitialised/unreset bank output register and out-of-range reads
  assign out  = rd_zero ? '0 : bank_rdata;
  assign busy = (state == CLEAR);

  ram_bank #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_bank (
    .clk  (clk),
    .we   (bank_we),
    .re   (bank_re),
    .addr (bank_addr),
    .wdata(bank_wdata),
    .rdata(bank_rdata)
  );

endmodule

// File: tb/tb_ram_sync_clr.sv
// Directed bench for ram_sync_clr with ADDR_W=4; expectations follow RAM_SYNC_OOB_FAULT_EN if defined.
module tb_ram_sync_clr;

  logic        clk = 1'b0;
  logic        reset, clear, req, load;
  logic [15:0] address, in, out;
  logic        rvalid, busy, fault;
  int          n_pass = 0;
  int          n_total = 0;
  int          nb;

  always #5 clk = ~clk;

  ram_sync_clr #(
    .DATA_W (16),
    .ADDR_W (4),
    .CLR_VAL(16'h0000)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .clear  (clear),
    .req    (req),
    .load   (load),
    .address(address),
    .in     (in),
    .out    (out),
    .rvalid (rvalid),
    .busy   (busy),
    .fault  (fault)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req   = 1'b0;
    load  = 1'b0;
    clear = 1'b0;
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    req = 1'b1; load = 1'b1; address = a; in = d;
    tick();
    check("wr_no_rvalid", {31'd0, rvalid}, 32'd0);
    idle();
  endtask

  task automatic rd(input logic [15:0] a, input logic [15:0] exp, input string tag);
    req = 1'b1; load = 1'b0; address = a;
    tick();
    check({tag, "_rvalid"}, {31'd0, rvalid}, 32'd1);
    check({tag, "_out"}, {16'd0, out}, {16'd0, exp});
    idle();
  endtask

  // Cycles of busy=1 seen from now until busy drops, bounded.
  task automatic count_busy(output int n);
    n = 0;
    while (busy === 1'b1 && n < 64) begin
      tick();
      n++;
    end
  endtask

  initial begin
    reset = 1'b1; address = '0; in = '0;
    idle();
    tick(); tick();
    check("rst_out", {16'd0, out}, 32'd0);
    check("rst_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd1);
    check("rst_fault", {31'd0, fault}, 32'd0);
    reset = 1'b0;
    count_busy(nb);
    check("init_busy_len", nb, 32'd16);

    for (int a = 0; a < 16; a++) rd(16'(a), 16'h0000, "init_rd");

    // write then read next cycle, out holds afterwards
    wr(16'd5, 16'hBEEF);
    rd(16'd5, 16'hBEEF, "raw5");
    tick();
    check("raw5_pulse_end", {31'd0, rvalid}, 32'd0);
    check("raw5_hold", {16'd0, out}, 32'h0000BEEF);
    repeat (3) tick();
    check("raw5_hold3", {16'd0, out}, 32'h0000BEEF);

    // back-to-back reads give back-to-back pulses
    req = 1'b1; load = 1'b0; address = 16'd5;
    tick();
    check("b2b_v0", {31'd0, rvalid}, 32'd1);
    address = 16'd0;
    tick();
    check("b2b_v1", {31'd0, rvalid}, 32'd1);
    check("b2b_out1", {16'd0, out}, 32'd0);
    idle();
    tick();
    check("b2b_end", {31'd0, rvalid}, 32'd0);

    // upper address bits
    wr(16'h0013, 16'h1234);
`ifdef RAM_SYNC_OOB_FAULT_EN
    check("oob_fault_set", {31'd0, fault}, 32'd1);
    rd(16'h0013, 16'h0000, "oob_rd");
    rd(16'h0003, 16'h0000, "oob_wr_suppressed");
    check("oob_fault_sticky", {31'd0, fault}, 32'd1);
`else
    check("alias_fault", {31'd0, fault}, 32'd0);
    rd(16'h0003, 16'h1234, "alias_rd3");
    rd(16'h0013, 16'h1234, "alias_rd13");
`endif

    // clear wins over a coincident write
    wr(16'd2, 16'h5555);
    rd(16'd2, 16'h5555, "pre_clr2");
    clear = 1'b1; req = 1'b1; load = 1'b1; address = 16'd2; in = 16'hAAAA;
    tick();
    idle();
    check("clr_no_rvalid", {31'd0, rvalid}, 32'd0);
    count_busy(nb);
    check("clr_busy_len", nb, 32'd16);
    rd(16'd2, 16'h0000, "post_clr2");
    rd(16'd5, 16'h0000, "post_clr5");
`ifdef RAM_SYNC_OOB_FAULT_EN
    check("fault_survives_clear", {31'd0, fault}, 32'd1);
`else
    check("fault_tied", {31'd0, fault}, 32'd0);
`endif

    // requests and a second clear during busy are dropped
    clear = 1'b1;
    tick();
    idle();
    nb = 0;
    while (busy === 1'b1 && nb < 64) begin
      req = 1'b1; load = ~nb[0]; address = 16'd1; in = 16'h7777;
      clear = (nb == 5);
      tick();
      nb++;
      check("busy_req_dropped", {31'd0, rvalid}, 32'd0);
    end
    idle();
    check("busy_len_with_reqs", nb, 32'd16);
    rd(16'd1, 16'h0000, "busy_wr_dropped");

    // reset cancels a read issued at the same edge
    wr(16'd5, 16'h4242);
    reset = 1'b1; req = 1'b1; load = 1'b0; address = 16'd5;
    tick();
    idle();
    check("rst_cancel_rvalid", {31'd0, rvalid}, 32'd0);
    check("rst_cancel_out", {16'd0, out}, 32'd0);
    check("rst_cancel_busy", {31'd0, busy}, 32'd1);
    check("rst_cancel_fault", {31'd0, fault}, 32'd0);
    reset = 1'b0;
    count_busy(nb);
    check("rst_cancel_busy_len", nb, 32'd16);

    // reset part-way through a clear restarts it from zero
    wr(16'd9, 16'h9999);
    clear = 1'b1;
    tick();
    idle();
    repeat (6) tick();
    reset = 1'b1;
    tick();
    check("midclr_busy", {31'd0, busy}, 32'd1);
    reset = 1'b0;
    count_busy(nb);
    check("midclr_busy_len", nb, 32'd16);
    rd(16'd9, 16'h0000, "midclr_rd9");
    rd(16'd5, 16'h0000, "midclr_rd5");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
